// File: rtl/half_adder_pkg.sv
// Shared constants for the bit-sliced half adder: default lane count and
// per-lane truth tables indexed by {a,b}.
package half_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;

  // Bit {a,b} of each table is the lane output for that input pair.
  localparam logic [3:0] HA_SUM_LUT   = 4'b0110;
  localparam logic [3:0] HA_CARRY_LUT = 4'b1000;

endpackage

// File: rtl/half_adder_cell.sv
// One half-adder lane: sum = a XOR b, carry = a AND b, purely combinational.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes with a combinational result and an
// optional one-cycle registered copy qualified by out_valid.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid
);

  generate
    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_lane
      half_adder_cell u_cell (
        .a     (a[gi]),
        .b     (b[gi]),
        .sum   (sum[gi]),
        .carry (carry[gi])
      );
    end

    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] sum_reg;
      logic [WIDTH-1:0] carry_reg;
      logic             valid_reg;

      // Data holds when idle; only the valid flag tracks in_valid every cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_reg   <= '0;
          carry_reg <= '0;
          valid_reg <= 1'b0;
        end else begin
          valid_reg <= in_valid;
          if (in_valid) begin
            sum_reg   <= sum;
            carry_reg <= carry;
          end
        end
      end

      assign sum_q     = sum_reg;
      assign carry_q   = carry_reg;
      assign out_valid = valid_reg;
    end else begin : g_noreg
      logic unused_ok;
      assign unused_ok = ^{clk, rst_n, in_valid};

      assign sum_q     = '0;
      assign carry_q   = '0;
      assign out_valid = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench: directed vectors push expected results, a negedge monitor
// pops and compares whenever out_valid is presented.
module tb_half_adder;
  import half_adder_pkg::*;

  typedef struct packed {
    logic [7:0] s;
    logic [7:0] c;
  } exp_t;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       in_valid;

  logic [7:0] sum8, carry8, sumq8, carryq8;
  logic       ov8;
  logic [7:0] sum0, carry0, sumq0, carryq0;
  logic       ov0;
  logic [0:0] sum1, carry1, sumq1, carryq1;
  logic       ov1;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  half_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .sum(sum8), .carry(carry8), .sum_q(sumq8), .carry_q(carryq8), .out_valid(ov8)
  );

  half_adder #(.WIDTH(8), .REG_OUT(1'b0)) u_w8_noreg (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .sum(sum0), .carry(carry0), .sum_q(sumq0), .carry_q(carryq0), .out_valid(ov0)
  );

  half_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a[0:0]), .b(b[0:0]), .in_valid(in_valid),
    .sum(sum1), .carry(carry1), .sum_q(sumq1), .carry_q(carryq1), .out_valid(ov1)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected entry per presented result.
  always @(negedge clk) begin
    check("noreg_regs_zero", {7'd0, ov0, sumq0 | carryq0}, 16'h0000);
    check("w1_valid_matches", {15'd0, ov1}, {15'd0, ov8});
    if (ov8 === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 16'h0001, 16'h0000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("w8_sum_q",   {8'd0, sumq8},   {8'd0, e.s});
        check("w8_carry_q", {8'd0, carryq8}, {8'd0, e.c});
        check("w1_regs", {14'd0, sumq1, carryq1}, {14'd0, e.s[0], e.c[0]});
        check("w8_q_exclusive", {8'd0, sumq8 & carryq8}, 16'h0000);
      end
    end
  end

  // Issue one captured vector; comb outputs checked before the capture edge.
  task automatic apply(input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] es, input logic [7:0] ec);
    exp_t e;
    a = va;
    b = vb;
    in_valid = 1'b1;
    e.s = es;
    e.c = ec;
    sb.push_back(e);
    #1;
    check("w8_sum",   {8'd0, sum8},   {8'd0, es});
    check("w8_carry", {8'd0, carry8}, {8'd0, ec});
    check("noreg_comb", {sum0, carry0}, {es, ec});
    $display("vec a=%h b=%h expect sum=%h carry=%h", va, vb, es, ec);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [7:0] va, input logic [7:0] vb);
    a = va;
    b = vb;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk_en      = 1'b0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    a           = 8'h00;
    b           = 8'h00;

    // Truth table with no clock running and reset held.
    #1;
    check("reset_regs_w8", {7'd0, ov8, sumq8 | carryq8}, 16'h0000);
    check("reset_regs_w1", {13'd0, ov1, sumq1, carryq1}, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] idx;
      idx = 2'(i);
      a = {8{idx[1]}};
      b = {8{idx[0]}};
      #5;
      check("comb_w1", {14'd0, carry1, sum1}, {14'd0, HA_CARRY_LUT[idx], HA_SUM_LUT[idx]});
      check("comb_w8", {carry8, sum8}, {{8{HA_CARRY_LUT[idx]}}, {8{HA_SUM_LUT[idx]}}});
      $display("comb a=%b b=%b sum=%b carry=%b", idx[1], idx[0], sum1, carry1);
    end

    rst_n  = 1'b1;
    clk_en = 1'b1;
    @(posedge clk);
    #1;

    // Single 1+1 capture, then idle with changed inputs: data must hold.
    apply(8'h01, 8'h01, 8'h00, 8'h01);
    idle(8'hFF, 8'h00);
    check("hold_valid_low", {15'd0, ov8}, 16'h0000);
    check("hold_w8", {sumq8, carryq8}, {8'h00, 8'h01});
    check("hold_w1", {14'd0, sumq1, carryq1}, {14'd0, 1'b0, 1'b1});

    // Assorted 8-lane patterns, back to back.
    apply(8'hF0, 8'h3C, 8'hCC, 8'h30);
    apply(8'hAA, 8'h55, 8'hFF, 8'h00);
    apply(8'hFF, 8'hFF, 8'h00, 8'hFF);
    apply(8'h12, 8'h34, 8'h26, 8'h10);
    idle(8'h00, 8'h00);

    // Streaming sweep 00,01,10,11 on every lane.
    apply(8'h00, 8'h00, 8'h00, 8'h00);
    apply(8'h00, 8'hFF, 8'hFF, 8'h00);
    apply(8'hFF, 8'h00, 8'hFF, 8'h00);
    apply(8'hFF, 8'hFF, 8'h00, 8'hFF);
    idle(8'h00, 8'h00);
    idle(8'h00, 8'h00);

    // Mid-stream asynchronous reset between edges.
    apply(8'h0F, 8'h0F, 8'h00, 8'h0F);
    in_valid = 1'b0;
    #1;
    check("pre_reset_valid", {15'd0, ov8}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("async_reset_w8", {7'd0, ov8, sumq8 | carryq8}, 16'h0000);
    check("async_reset_w1", {13'd0, ov1, sumq1, carryq1}, 16'h0000);
    a = 8'hAA;
    b = 8'h55;
    #1;
    check("comb_in_reset", {sum8, carry8}, {8'hFF, 8'h00});
    sb.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    apply(8'hC3, 8'h81, 8'h42, 8'h81);
    idle(8'h00, 8'h00);
    idle(8'h00, 8'h00);

    check("scoreboard_drained", 16'(sb.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
- Bit-sliced half adder: for each lane i, sum[i] = a[i] XOR b[i] and carry[i] = a[i] AND b[i].
- Combinational outputs serve glue logic and the truth-table bench.
- A registered copy with a valid flag serves pipelined datapaths.
- Leaf arithmetic block; the lowest level of adder trees and counters.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (>=1).
- REG_OUT, 1, 1 = registered outputs sum_q/carry_q/out_valid are implemented; 0 = they are tied to 0.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  addend A, one bit per lane
- b  input  WIDTH  addend B, one bit per lane
- in_valid  input  1  a/b qualify for capture this cycle
- sum  output  WIDTH  combinational sum, a XOR b
- carry  output  WIDTH  combinational carry, a AND b
- sum_q  output  WIDTH  registered sum
- carry_q  output  WIDTH  registered carry
- out_valid  output  1  sum_q/carry_q hold a captured result

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Combinational path:
  - sum/carry depend only on a/b; zero latency.
  - Independent of clk, rst_n and in_valid; valid even while in reset.
- Per-lane truth table (a b -> carry sum): 0 0 -> 0 0; 0 1 -> 0 1; 1 0 -> 0 1; 1 1 -> 1 0.
- Lanes are fully independent; no carry propagates between lanes.
- Registered path (REG_OUT=1):
  - On each rising clk with in_valid=1: sum_q <= a^b, carry_q <= a&b, out_valid <= 1. Latency is 1 cycle.
  - Rising clk with in_valid=0: sum_q/carry_q hold their value; out_valid <= 0.
  - No backpressure: every valid input is captured, and the result is presented for exactly the following cycle unless in_valid repeats.
  - Back-to-back in_valid gives one result per cycle.
- Reset:
  - rst_n low forces sum_q=0, carry_q=0, out_valid=0 immediately, without waiting for a clock edge.
  - Deassertion is synchronized externally. The first capture is at the first rising edge with rst_n high and in_valid=1.
  - Reset mid-stream discards the pending result; out_valid drops asynchronously.
- REG_OUT=0: sum_q, carry_q, out_valid are constant 0; no flops are inferred.
- X on a or b propagates to the corresponding lane only.
- Invariant: sum[i] and carry[i] are never both 1; the same holds for sum_q/carry_q.

Decomposition:
- Package half_adder_pkg:
  - DEFAULT_WIDTH=1
  - localparam truth-table constants for bench reuse: HA_SUM_LUT=4'b0110, HA_CARRY_LUT=4'b1000, indexed by {a,b}.
- Sub-module half_adder_cell: one-bit combinational XOR/AND.
  - Instantiated WIDTH times via generate.
  - Output register bank and valid flop live in the top.

Test Plan:
- WIDTH=1, drive {a,b}=00,01,10,11 with 5 time-unit spacing -> sum/carry = 0/0, 1/0, 1/0, 0/1 after each step, with no clock running.
- WIDTH=1, rst_n=1, in_valid=1 with a=1,b=1 at edge N -> sum_q=0, carry_q=1, out_valid=1 after edge N. At edge N+1 with in_valid=0 -> out_valid=0, sum_q/carry_q held.
- WIDTH=8, a=8'hF0, b=8'h3C, in_valid=1 -> sum=8'hCC, carry=8'h30 combinationally, and the same on sum_q/carry_q one cycle later.
- Assert rst_n=0 between clock edges while out_valid=1 -> out_valid, sum_q, carry_q go to 0 before the next edge. sum/carry still track a/b during reset.
- Streaming: in_valid held 1 for 4 cycles, a/b sweeping 00,01,10,11 -> out_valid high 4 consecutive cycles. carry_q sequence 0,0,0,1 and sum_q 0,1,1,0, each lagging the input by one cycle.
- REG_OUT=0, any stimulus -> sum_q=carry_q=out_valid=0 always; combinational outputs per the truth table.
